// File: rtl/vc_switch_allocator.sv
// vc_switch_allocator
// Two-stage separable input-first switch allocator for a VC router.
// Stage 1 picks one eligible VC per input port (round-robin per input).
// Stage 2 picks one input per output port (round-robin per output).
// Eligibility requires a valid route and an "on" downstream VC.
// Optional build macro: SA_OUTPUT_REG_EN registers all four outputs
// (1-cycle grant latency). Without it the outputs are combinational.
module vc_switch_allocator #(
    parameter int PORT_NUM  = 5,
    parameter int VC_NUM    = 2,
    parameter int PORT_SIZE = $clog2(PORT_NUM),
    parameter int VC_SIZE   = (VC_NUM > 1) ? $clog2(VC_NUM) : 1
) (
    input  logic                                           clk,
    input  logic                                           rst,
    input  logic [PORT_NUM-1:0][VC_NUM-1:0]                switch_request_i,
    input  logic [PORT_NUM-1:0][VC_NUM-1:0][PORT_SIZE-1:0] out_port_i,
    input  logic [PORT_NUM-1:0][VC_NUM-1:0][VC_SIZE-1:0]   downstream_vc_i,
    input  logic [PORT_NUM-1:0][VC_NUM-1:0]                on_off_i,
    output logic [PORT_NUM-1:0]                            valid_sel_o,
    output logic [PORT_NUM-1:0][VC_SIZE-1:0]               vc_sel_o,
    output logic [PORT_NUM-1:0][PORT_SIZE-1:0]             input_port_sel_o,
    output logic [PORT_NUM-1:0]                            valid_flit_o
);

    // Round-robin pointers: in_ptr per input (over VCs), out_ptr per output (over inputs)
    logic [PORT_NUM-1:0][VC_SIZE-1:0]   in_ptr_q,  in_ptr_d;
    logic [PORT_NUM-1:0][PORT_SIZE-1:0] out_ptr_q, out_ptr_d;

    logic [PORT_NUM-1:0][VC_NUM-1:0]    req;
    logic [PORT_NUM-1:0]                s1_vld;
    logic [PORT_NUM-1:0][VC_SIZE-1:0]   s1_vc;
    logic [PORT_NUM-1:0][PORT_SIZE-1:0] s1_port;

    logic [PORT_NUM-1:0]                valid_sel_d;
    logic [PORT_NUM-1:0][VC_SIZE-1:0]   vc_sel_d;
    logic [PORT_NUM-1:0][PORT_SIZE-1:0] input_port_sel_d;
    logic [PORT_NUM-1:0]                valid_flit_d;

    // Eligibility: request, in-range route, and downstream VC switched on
    always_comb begin
        req = '0;
        for (int p = 0; p < PORT_NUM; p++) begin
            for (int v = 0; v < VC_NUM; v++) begin
                if (switch_request_i[p][v] &&
                    (int'(out_port_i[p][v]) < PORT_NUM) &&
                    (int'(downstream_vc_i[p][v]) < VC_NUM)) begin
                    req[p][v] = on_off_i[out_port_i[p][v]][downstream_vc_i[p][v]];
                end
            end
        end
    end

    // Stage 1: per input, first eligible VC at or after in_ptr (wrapping)
    always_comb begin
        int idx;
        idx     = 0;
        s1_vld  = '0;
        s1_vc   = '0;
        s1_port = '0;
        for (int p = 0; p < PORT_NUM; p++) begin
            for (int k = 0; k < VC_NUM; k++) begin
                idx = (int'(in_ptr_q[p]) + k) % VC_NUM;
                if (!s1_vld[p] && req[p][idx]) begin
                    s1_vld[p]  = 1'b1;
                    s1_vc[p]   = VC_SIZE'(idx);
                    s1_port[p] = out_port_i[p][idx];
                end
            end
        end
    end

    // Stage 2: per output, first stage-1 winner at or after out_ptr (wrapping);
    // pointers advance only for full grants, and nothing is granted in reset
    always_comb begin
        int i;
        i                = 0;
        valid_sel_d      = '0;
        vc_sel_d         = '0;
        input_port_sel_d = '0;
        valid_flit_d     = '0;
        in_ptr_d         = in_ptr_q;
        out_ptr_d        = out_ptr_q;
        if (rst) begin
            for (int o = 0; o < PORT_NUM; o++) begin
                for (int k = 0; k < PORT_NUM; k++) begin
                    i = (int'(out_ptr_q[o]) + k) % PORT_NUM;
                    if (!valid_flit_d[o] && s1_vld[i] && (int'(s1_port[i]) == o)) begin
                        valid_flit_d[o]     = 1'b1;
                        input_port_sel_d[o] = PORT_SIZE'(i);
                        valid_sel_d[i]      = 1'b1;
                        vc_sel_d[i]         = s1_vc[i];
                        in_ptr_d[i]         = VC_SIZE'((int'(s1_vc[i]) + 1) % VC_NUM);
                        out_ptr_d[o]        = PORT_SIZE'((i + 1) % PORT_NUM);
                    end
                end
            end
        end
    end

    // Pointer state, cleared asynchronously by reset
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            in_ptr_q  <= '0;
            out_ptr_q <= '0;
        end else begin
            in_ptr_q  <= in_ptr_d;
            out_ptr_q <= out_ptr_d;
        end
    end

`ifdef SA_OUTPUT_REG_EN
    logic [PORT_NUM-1:0]                valid_sel_q;
    logic [PORT_NUM-1:0][VC_SIZE-1:0]   vc_sel_q;
    logic [PORT_NUM-1:0][PORT_SIZE-1:0] input_port_sel_q;
    logic [PORT_NUM-1:0]                valid_flit_q;

    // Registered grant outputs, one cycle after the grant is computed
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            valid_sel_q      <= '0;
            vc_sel_q         <= '0;
            input_port_sel_q <= '0;
            valid_flit_q     <= '0;
        end else begin
            valid_sel_q      <= valid_sel_d;
            vc_sel_q         <= vc_sel_d;
            input_port_sel_q <= input_port_sel_d;
            valid_flit_q     <= valid_flit_d;
        end
    end

    assign valid_sel_o      = valid_sel_q;
    assign vc_sel_o         = vc_sel_q;
    assign input_port_sel_o = input_port_sel_q;
    assign valid_flit_o     = valid_flit_q;
`else
    assign valid_sel_o      = valid_sel_d;
    assign vc_sel_o         = vc_sel_d;
    assign input_port_sel_o = input_port_sel_d;
    assign valid_flit_o     = valid_flit_d;
`endif

endmodule

// File: tb/tb_vc_switch_allocator.sv
// Bench for vc_switch_allocator: directed scenarios plus randomized traffic,
// compared against a distance-based round-robin reference model.
module tb_vc_switch_allocator;

    localparam int P  = 5;
    localparam int V  = 2;
    localparam int PS = 3;
    localparam int VS = 1;

    logic clk;
    logic rst;
    logic [P-1:0][V-1:0]         sr;
    logic [P-1:0][V-1:0][PS-1:0] op;
    logic [P-1:0][V-1:0][VS-1:0] dvc;
    logic [P-1:0][V-1:0]         oo;
    logic [P-1:0]                valid_sel_o;
    logic [P-1:0][VS-1:0]        vc_sel_o;
    logic [P-1:0][PS-1:0]        input_port_sel_o;
    logic [P-1:0]                valid_flit_o;

    vc_switch_allocator #(.PORT_NUM(P), .VC_NUM(V), .PORT_SIZE(PS), .VC_SIZE(VS)) dut (
        .clk              (clk),
        .rst              (rst),
        .switch_request_i (sr),
        .out_port_i       (op),
        .downstream_vc_i  (dvc),
        .on_off_i         (oo),
        .valid_sel_o      (valid_sel_o),
        .vc_sel_o         (vc_sel_o),
        .input_port_sel_o (input_port_sel_o),
        .valid_flit_o     (valid_flit_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // reference model state
    int in_ptr_m[P];
    int out_ptr_m[P];
    int nin[P];
    int nout[P];
    logic [P-1:0]         exp_vsel;
    logic [P-1:0][VS-1:0] exp_vc;
    logic [P-1:0][PS-1:0] exp_isel;
    logic [P-1:0]         exp_vflit;

    // outputs captured at the sampling point of the last step
    logic [P-1:0]         s_vsel;
    logic [P-1:0][VS-1:0] s_vc;
    logic [P-1:0][PS-1:0] s_isel;
    logic [P-1:0]         s_vflit;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
        end
    endtask

    function automatic bit elig(input int p, input int v);
        int o;
        o = int'(op[p][v]);
        if (!sr[p][v] || o >= P) return 1'b0;
        return oo[o][int'(dvc[p][v])];
    endfunction

    // Each input offers the eligible VC closest after its pointer; each output
    // takes the offering input closest after its pointer.
    task automatic model_eval();
        int cand[P];
        int best, bd, d;
        exp_vsel = '0; exp_vc = '0; exp_isel = '0; exp_vflit = '0;
        for (int p = 0; p < P; p++) begin
            nin[p]  = in_ptr_m[p];
            nout[p] = out_ptr_m[p];
        end
        if (!rst) return;
        for (int p = 0; p < P; p++) begin
            cand[p] = -1;
            bd = V;
            for (int v = 0; v < V; v++) begin
                if (elig(p, v)) begin
                    d = (v - in_ptr_m[p] + V) % V;
                    if (d < bd) begin bd = d; cand[p] = v; end
                end
            end
        end
        for (int o = 0; o < P; o++) begin
            best = -1;
            bd = P;
            for (int p = 0; p < P; p++) begin
                if (cand[p] >= 0 && int'(op[p][cand[p]]) == o) begin
                    d = (p - out_ptr_m[o] + P) % P;
                    if (d < bd) begin bd = d; best = p; end
                end
            end
            if (best >= 0) begin
                exp_vsel[best] = 1'b1;
                exp_vc[best]   = VS'(cand[best]);
                exp_vflit[o]   = 1'b1;
                exp_isel[o]    = PS'(best);
                nin[best]      = (cand[best] + 1) % V;
                nout[o]        = (best + 1) % P;
            end
        end
    endtask

    task automatic model_commit();
        for (int p = 0; p < P; p++) begin
            in_ptr_m[p]  = rst ? nin[p]  : 0;
            out_ptr_m[p] = rst ? nout[p] : 0;
        end
    endtask

    task automatic sample_and_check();
        s_vsel  = valid_sel_o;
        s_vc    = vc_sel_o;
        s_isel  = input_port_sel_o;
        s_vflit = valid_flit_o;
        chk("valid_sel", 32'(s_vsel), 32'(exp_vsel));
        chk("vc_sel", 32'(s_vc), 32'(exp_vc));
        chk("in_port_sel", 32'(s_isel), 32'(exp_isel));
        chk("valid_flit", 32'(s_vflit), 32'(exp_vflit));
    endtask

    // Called just after a rising edge with inputs already applied;
    // returns just after the next rising edge.
    task automatic step();
        #1;
        model_eval();
`ifndef SA_OUTPUT_REG_EN
        sample_and_check();
`endif
        @(posedge clk);
        model_commit();
        #1;
`ifdef SA_OUTPUT_REG_EN
        sample_and_check();
`endif
    endtask

    task automatic clear_in();
        sr = '0; op = '0; dvc = '0; oo = '1;
    endtask

    task automatic do_reset();
        clear_in();
        rst = 1'b0;
        step();
        rst = 1'b1;
    endtask

    task automatic rand_in();
        for (int p = 0; p < P; p++) begin
            for (int v = 0; v < V; v++) begin
                sr[p][v]  = 1'($urandom_range(0, 1));
                op[p][v]  = ($urandom_range(0, 9) == 0) ? PS'($urandom_range(5, 7))
                                                         : PS'($urandom_range(0, 4));
                dvc[p][v] = VS'($urandom_range(0, 1));
                oo[p][v]  = ($urandom_range(0, 3) != 0);
            end
        end
    endtask

    initial begin
        for (int p = 0; p < P; p++) begin in_ptr_m[p] = 0; out_ptr_m[p] = 0; end
        rst = 1'b0;
        clear_in();
        @(posedge clk);
        #1;

        // reset with a request active, then first grant after release
        sr[0][1] = 1'b1; op[0][1] = 3'd2;
        #2;
        chk("rst_vsel", 32'(valid_sel_o), 32'd0);
        chk("rst_vc", 32'(vc_sel_o), 32'd0);
        chk("rst_isel", 32'(input_port_sel_o), 32'd0);
        chk("rst_vflit", 32'(valid_flit_o), 32'd0);
        step();
        rst = 1'b1;
        step();
        chk("first_vsel0", 32'(s_vsel[0]), 32'd1);
        chk("first_vc0", 32'(s_vc[0]), 32'd1);
        chk("first_vflit2", 32'(s_vflit[2]), 32'd1);
        chk("first_isel2", 32'(s_isel[2]), 32'd0);

        // all inputs to output 3: rotate 0..4, one grant per cycle
        do_reset();
        for (int p = 0; p < P; p++) begin sr[p][0] = 1'b1; op[p][0] = 3'd3; end
        for (int i = 0; i < P; i++) begin
            step();
            chk("cont_isel3", 32'(s_isel[3]), 32'(i));
            chk("cont_one", 32'($countones(s_vsel)), 32'd1);
        end

        // both VCs of input 1 to output 4: alternate
        do_reset();
        sr[1] = 2'b11; op[1][0] = 3'd4; op[1][1] = 3'd4;
        for (int i = 0; i < 4; i++) begin
            step();
            chk("vcrot_vc1", 32'(s_vc[1]), 32'(i % 2));
        end

        // flow control off, then on
        do_reset();
        oo[2][1] = 1'b0;
        sr[0][0] = 1'b1; op[0][0] = 3'd2; dvc[0][0] = 1'b1;
        step();
        chk("flow_off_vsel", 32'(s_vsel), 32'd0);
        chk("flow_off_vflit", 32'(s_vflit), 32'd0);
        oo[2][1] = 1'b1;
        step();
        chk("flow_on_vflit2", 32'(s_vflit[2]), 32'd1);
        chk("flow_on_vsel0", 32'(s_vsel[0]), 32'd1);

        // stage-2 loss keeps the input pointer
        do_reset();
        sr[1][0] = 1'b1; op[1][0] = 3'd1;
        step();
        chk("s2_pre_isel1", 32'(s_isel[1]), 32'd1);
        clear_in();
        sr[0] = 2'b11; op[0][0] = 3'd1; op[0][1] = 3'd1;
        sr[2][0] = 1'b1; op[2][0] = 3'd1;
        step();
        chk("s2_lose_isel1", 32'(s_isel[1]), 32'd2);
        chk("s2_lose_vsel0", 32'(s_vsel[0]), 32'd0);
        step();
        chk("s2_win_vsel0", 32'(s_vsel[0]), 32'd1);
        chk("s2_win_vc0", 32'(s_vc[0]), 32'd0);
        chk("s2_win_isel1", 32'(s_isel[1]), 32'd0);

        // out-of-range route: no grant and no pointer movement
        do_reset();
        sr[3][0] = 1'b1; op[3][0] = 3'd7;
        step();
        chk("inv_vsel", 32'(s_vsel), 32'd0);
        chk("inv_vflit", 32'(s_vflit), 32'd0);
        sr[3] = 2'b11; op[3][0] = 3'd0; op[3][1] = 3'd0;
        step();
        chk("inv_after_vsel3", 32'(s_vsel[3]), 32'd1);
        chk("inv_after_vc3", 32'(s_vc[3]), 32'd0);

        // randomized traffic with occasional reset cycles
        do_reset();
        for (int n = 0; n < 400; n++) begin
            rand_in();
            rst = ($urandom_range(0, 49) != 0);
            step();
        end
        rst = 1'b1;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/vc_switch_allocator.md
# vc_switch_allocator

Switch allocator for the VC-based router pipeline, following the single-VC-per-port allocator. It arbitrates VC_NUM virtual channels per input port for PORT_NUM output ports using a two-stage separable input-first scheme. Round-robin pointers are stored per input and per output, and the allocator respects on/off flow control per downstream VC. It sits between the input blocks and the crossbar, and drives the input-side VC/port selects and the crossbar input selects.

## Interface
- PORT_NUM, 5, number of router ports (inputs = outputs)
- VC_NUM, 2, virtual channels per input port
- PORT_SIZE, $clog2(PORT_NUM), port index width
- VC_SIZE, max(1,$clog2(VC_NUM)), VC index width
- clk  in  1  clock, all state on rising edge
- rst  in  1  reset, asynchronous, active-low
- switch_request_i  in  [PORT_NUM][VC_NUM]  upstream VC holds a flit requesting the switch
- out_port_i  in  [PORT_NUM][VC_NUM] x PORT_SIZE  routed output port of each upstream VC
- downstream_vc_i  in  [PORT_NUM][VC_NUM] x VC_SIZE  allocated downstream VC of each upstream VC
- on_off_i  in  [PORT_NUM][VC_NUM]  1 = downstream VC (output port, vc) may accept a flit
- valid_sel_o  out  [PORT_NUM]  input port p sends a flit this cycle
- vc_sel_o  out  [PORT_NUM] x VC_SIZE  upstream VC selected at input p
- input_port_sel_o  out  [PORT_NUM] x PORT_SIZE  crossbar: input feeding output o
- valid_flit_o  out  [PORT_NUM]  output o carries a valid flit

## Operation
- Eligibility: req[p][v] = switch_request_i[p][v] & (out_port_i[p][v] < PORT_NUM) & on_off_i[out_port_i[p][v]][downstream_vc_i[p][v]]. An out-of-range out_port is never eligible.
- Stage 1 (input arbitration): each input p picks one eligible VC, round-robin, searching from in_ptr[p] upward with wrap-around mod VC_NUM.
- Stage 2 (output arbitration): each output o picks one input among those whose stage-1 VC targets o, round-robin, searching from out_ptr[o] with wrap-around mod PORT_NUM.
- Grant to (p,v,o):
  - valid_sel_o[p]=1, vc_sel_o[p]=v
  - valid_flit_o[o]=1, input_port_sel_o[o]=p
- Non-granted fields are 0.
- Pointer update at the clock edge, only on a full grant:
  - in_ptr[p] <= (v+1) mod VC_NUM
  - out_ptr[o] <= (p+1) mod PORT_NUM
- A stage-1 winner that loses stage 2 leaves in_ptr[p] unchanged, which prevents VC starvation.
- Each input is granted at most once per cycle, and each output at most once per cycle.
- With VC_NUM=1, in_ptr is a constant 0 and vc_sel_o is always 0.

## Timing
- Grants are combinational from inputs in the same cycle; pointer state updates on the next rising clk edge.
- rst low, at any time: in_ptr and out_ptr are asynchronously set to 0. A pending request mid-arbitration is dropped, and the pointers do not advance on that edge.
- Reset values (registered outputs, see Configuration): valid_sel_o=0, vc_sel_o=0, input_port_sel_o=0, valid_flit_o=0.
- Simultaneous requests from all inputs to one output: exactly one grant per cycle, rotating fairly. Each input is served once within PORT_NUM consecutive cycles if its request is held.
- An on_off_i drop is seen in the same cycle: the affected VC is not granted that cycle.

## Configuration
- SA_OUTPUT_REG_EN defined:
  - All four outputs are registered; grant-to-output latency is 1 cycle.
  - The outputs reset asynchronously to 0.
  - Pointers still update on the edge where the grant is computed.
- SA_OUTPUT_REG_EN undefined: outputs are combinational; 0-cycle latency.

## Test plan
- Reset: rst=0 with requests active -> all outputs 0; after release with P0.VC1 requesting out 2 (on) -> valid_sel_o[0]=1, vc_sel_o[0]=1, valid_flit_o[2]=1, input_port_sel_o[2]=0.
- Output contention: P0..P4 all VC0 to out 3, held for 5 cycles -> input_port_sel_o[3] sequence 0,1,2,3,4, one grant per cycle.
- VC rotation: P1 VC0 and VC1 both to out 4, held -> vc_sel_o[1] alternates 0,1,0,1.
- Flow control: on_off_i[2][1]=0, P0.VC0 to (out 2, dvc 1) -> no grant; raise on_off_i[2][1] -> grant in the same cycle (or the next cycle with SA_OUTPUT_REG_EN).
- Stage-2 loss: P0 VC0 loses out 1 to P2 -> next cycle P0 still offers VC0 (in_ptr[0] unchanged) and wins.
- Invalid route: out_port_i[3][0]=7 with PORT_NUM=5 -> no grant, and pointers unchanged.
